hpss_spec_writer: RTL and testbench

//  Producer side of the HPSS harmonic/percussive spectrum buffers. Consumes one forward-FFT frame
//  per start pulse and computes per-bin magnitude. Writes harmonic (time-median) and percussive
//  (frequency-median) magnitudes to the H/P buffers that the mask/iFFT stage reads.

---
 rtl/hpss_pkg.sv | 22 ++
 rtl/hpss_med3.sv | 31 +++
 rtl/hpss_spec_writer.sv | 248 ++++++++++++++++++++++++
 tb/tb_hpss_spec_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpss_pkg.sv
// -----------------------------------------------------------------------------
// hpss_pkg
//   Shared definitions for the HPSS spectrum writer:
//     FFT_LEN  default bins per frame
//     ADDR_W   bin index width
//     MAG_W    magnitude width (unsigned)
//     state_t  frame-control FSM states
// -----------------------------------------------------------------------------
package hpss_pkg;

    localparam int FFT_LEN = 1024;
    localparam int ADDR_W  = $clog2(FFT_LEN);
    localparam int MAG_W   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hpss_med3.sv
// -----------------------------------------------------------------------------
// hpss_med3
//   Combinational median of three unsigned values.
//   Ports:
//     a, b, c  in   W   operands
//     med      out  W   median of {a, b, c}
// -----------------------------------------------------------------------------
module hpss_med3
    import hpss_pkg::*;
#(
    parameter int W = MAG_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] med
);

    logic [W-1:0] lo_ab;
    logic [W-1:0] hi_ab;
    logic [W-1:0] hi_clip;

    // med = max(min(a,b), min(max(a,b),c))
    always_comb begin
        lo_ab   = (a < b) ? a : b;
        hi_ab   = (a < b) ? b : a;
        hi_clip = (hi_ab < c) ? hi_ab : c;
        med     = (lo_ab > hi_clip) ? lo_ab : hi_clip;
    end

endmodule

// File: rtl/hpss_spec_writer.sv
// -----------------------------------------------------------------------------
// hpss_spec_writer
//   Producer side of the HPSS harmonic/percussive buffers. For each armed frame
//   it takes FFT_LEN bins, forms per-bin magnitude, and writes the frequency
//   median (percussive) and the time median over the last three frames
//   (harmonic) to the H/P buffers. done pulses once the frame is stored.
//
//   Build option: HPSS_MAG_L1_EN selects |re|+|im| instead of re^2+im^2.
//
//   Ports:
//     clk        in   1       system clock
//     rst_n      in   1       asynchronous active-low reset
//     start      in   1       rising edge arms a frame (ignored while busy)
//     in_valid   in   1       fft_data valid, ascending bins, gaps allowed
//     fft_data   in   64      {imag[63:32], real[31:0]} signed
//     busy       out  1       frame in progress
//     wr_en      out  1       write strobe for H and P buffers
//     wr_addr    out  ADDR_W  bin index of the write
//     wr_data_H  out  64      harmonic magnitude
//     wr_data_P  out  64      percussive magnitude
//     done       out  1       one-cycle pulse after the last bin is written
// -----------------------------------------------------------------------------
module hpss_spec_writer #(
    parameter int FFT_LEN = 1024,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [63:0]       fft_data,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data_H,
    output logic [63:0]       wr_data_P,
    output logic              done
);
    import hpss_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

`ifdef HPSS_MAG_L1_EN
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        // -2^31 maps to 0x8000_0000, which is +2^31 read as unsigned
        return v[31] ? 32'(~v + 32'sd1) : 32'(v);
    endfunction

    function automatic logic [63:0] mag_term(input logic signed [31:0] v);
        return {32'd0, abs32(v)};
    endfunction
`else
    function automatic logic [63:0] mag_term(input logic signed [31:0] v);
        logic signed [63:0] w;
        w = 64'(v);
        return $unsigned(w * w);
    endfunction
`endif

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd2) ? 2'd2 : v + 2'd1;
    endfunction

    state_t            state;
    logic              start_d;
    logic [ADDR_W-1:0] bin_cnt;
    logic [1:0]        frame_cnt;
    logic              accept;

    logic signed [31:0] re_in;
    logic signed [31:0] im_in;

    logic [63:0]       term_re_p0, term_im_p0;
    logic [ADDR_W-1:0] bin_p0;
    logic              vld_p0;

    logic [63:0]       mag_p1;
    logic [ADDR_W-1:0] bin_p1;
    logic              vld_p1;

    logic [63:0]       prev_mag, cur_mag;
    logic              tail_pend;
    logic              emit_p2;
    logic [ADDR_W-1:0] addr_nxt;
    logic [63:0]       pa, pc, p_med;
    logic [63:0]       p_p2, m_p2, h1_p2, h2_p2;
    logic [ADDR_W-1:0] addr_p2;
    logic              vld_p2;

    logic [63:0]       ha, hb, h_med;
    logic [63:0]       h_p3, p_p3, m_p3, h1_p3;
    logic [ADDR_W-1:0] addr_p3;
    logic              vld_p3;

    logic [63:0]       hist1 [FFT_LEN];
    logic [63:0]       hist2 [FFT_LEN];

    assign re_in  = fft_data[31:0];
    assign im_in  = fft_data[63:32];
    assign accept = (state == RUN) && in_valid;

    // Bin k is emitted when bin k+1 arrives; the last bin is emitted by the
    // tail cycle that follows, with its missing right neighbour replicated.
    assign emit_p2 = tail_pend || (vld_p1 && (bin_p1 != '0));

    always_comb begin
        if (tail_pend) begin
            pa       = prev_mag;
            pc       = cur_mag;
            addr_nxt = LAST_BIN;
        end else begin
            pa       = (bin_p1 == ONE) ? cur_mag : prev_mag;
            pc       = mag_p1;
            addr_nxt = bin_p1 - ONE;
        end
    end

    // Missing history is replaced by the current frame's magnitude.
    always_comb begin
        case (frame_cnt)
            2'd0:    ha = m_p2;
            2'd1:    ha = h1_p2;
            default: ha = h2_p2;
        endcase
        hb = (frame_cnt == 2'd2) ? h1_p2 : m_p2;
    end

    hpss_med3 #(.W(MAG_W)) u_med_p (
        .a   (pa),
        .b   (cur_mag),
        .c   (pc),
        .med (p_med)
    );

    hpss_med3 #(.W(MAG_W)) u_med_h (
        .a   (ha),
        .b   (hb),
        .c   (m_p2),
        .med (h_med)
    );

    always_ff @(posedge clk) begin
        // p0: per-component square (or abs)
        if (accept) begin
            term_re_p0 <= mag_term(re_in);
            term_im_p0 <= mag_term(im_in);
            bin_p0     <= bin_cnt;
        end
        // p1: magnitude sum
        if (vld_p0) begin
            mag_p1 <= term_re_p0 + term_im_p0;
            bin_p1 <= bin_p0;
        end
        // p2: neighbour window, percussive median, history read issued
        if (vld_p1) begin
            prev_mag <= cur_mag;
            cur_mag  <= mag_p1;
        end
        if (emit_p2) begin
            p_p2    <= p_med;
            m_p2    <= cur_mag;
            addr_p2 <= addr_nxt;
        end
        // p3: harmonic median
        if (vld_p2) begin
            h_p3    <= h_med;
            p_p3    <= p_p2;
            m_p3    <= m_p2;
            h1_p3   <= h1_p2;
            addr_p3 <= addr_p2;
        end
    end

    // History RAMs: read bin k two cycles before its write, shift on write.
    always_ff @(posedge clk) begin
        if (emit_p2) begin
            h1_p2 <= hist1[addr_nxt];
            h2_p2 <= hist2[addr_nxt];
        end
        if (vld_p3) begin
            hist1[addr_p3] <= m_p3;
            hist2[addr_p3] <= h1_p3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_d   <= 1'b0;
            bin_cnt   <= '0;
            frame_cnt <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            tail_pend <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data_H <= '0;
            wr_data_P <= '0;
        end else begin
            start_d   <= start;
            done      <= 1'b0;
            vld_p0    <= accept;
            vld_p1    <= vld_p0;
            vld_p2    <= emit_p2;
            vld_p3    <= vld_p2;
            tail_pend <= vld_p1 && (bin_p1 == LAST_BIN);
            // output stage: buffer write
            wr_en     <= vld_p3;
            if (vld_p3) begin
                wr_addr   <= addr_p3;
                wr_data_H <= h_p3;
                wr_data_P <= p_p3;
            end

            case (state)
                IDLE: begin
                    if (start && !start_d) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        bin_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        bin_cnt <= bin_cnt + ONE;
                        if (bin_cnt == LAST_BIN) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (vld_p3 && (addr_p3 == LAST_BIN)) state <= DONE;
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    frame_cnt <= sat_inc2(frame_cnt);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpss_spec_writer.sv
// -----------------------------------------------------------------------------
// tb_hpss_spec_writer
//   Directed bench for hpss_spec_writer. Frames are driven from stimulus
//   arrays; a reference model (sort-based median, frame history) supplies the
//   expected H/P per bin, alongside hand-computed spot values.
//   Honours HPSS_MAG_L1_EN for the magnitude definition.
// -----------------------------------------------------------------------------
module tb_hpss_spec_writer;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] fft_data = '0;
    logic        busy;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data_H;
    logic [63:0] wr_data_P;
    logic        done;

    hpss_spec_writer #(.FFT_LEN(N), .ADDR_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .fft_data  (fft_data),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data_H (wr_data_H),
        .wr_data_P (wr_data_P),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // write / done logger
    logic [63:0] log_H   [N];
    logic [63:0] log_P   [N];
    int unsigned log_cyc [N];
    int unsigned wr_total = 0;
    int unsigned seq_err = 0;
    int unsigned done_total = 0;
    int unsigned done_cyc = 0;
    int          last_addr = -1;

    always @(negedge clk) begin
        if (wr_en) begin
            if (!((int'(wr_addr) == last_addr + 1) || (wr_addr == 10'd0))) seq_err <= seq_err + 1;
            last_addr        <= int'(wr_addr);
            log_H[wr_addr]   <= wr_data_H;
            log_P[wr_addr]   <= wr_data_P;
            log_cyc[wr_addr] <= cyc;
            wr_total         <= wr_total + 1;
        end
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
    end

    // stimulus and model state
    logic signed [31:0] re_v [N];
    logic signed [31:0] im_v [N];
    int unsigned        acc_cyc [N];
    logic [63:0]        mag_m [N];
    logic [63:0]        hist1_m [N];
    logic [63:0]        hist2_m [N];
    logic [63:0]        exp_H [N];
    logic [63:0]        exp_P [N];
    logic [63:0]        save_P [N];
    int                 fcount = 0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] med_ref(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [63:0] x, y, z, t;
        x = a; y = b; z = c;
        if (x > y) begin t = x; x = y; y = t; end
        if (y > z) begin t = y; y = z; z = t; end
        if (x > y) begin t = x; x = y; y = t; end
        return y;
    endfunction

    function automatic logic [63:0] mag_ref(input logic signed [31:0] r, input logic signed [31:0] i);
        longint rl, il;
        rl = r;
        il = i;
`ifdef HPSS_MAG_L1_EN
        return $unsigned(rl < 0 ? -rl : rl) + $unsigned(il < 0 ? -il : il);
`else
        return $unsigned(rl * rl) + $unsigned(il * il);
`endif
    endfunction

    task automatic build_expected();
        for (int k = 0; k < N; k++) mag_m[k] = mag_ref(re_v[k], im_v[k]);
        for (int k = 0; k < N; k++) begin
            exp_P[k] = med_ref(mag_m[(k == 0) ? 0 : k - 1], mag_m[k], mag_m[(k == N - 1) ? N - 1 : k + 1]);
            case (fcount)
                0:       exp_H[k] = mag_m[k];
                1:       exp_H[k] = med_ref(hist1_m[k], mag_m[k], mag_m[k]);
                default: exp_H[k] = med_ref(hist2_m[k], hist1_m[k], mag_m[k]);
            endcase
        end
    endtask

    task automatic fill(input logic signed [31:0] r, input logic signed [31:0] i);
        for (int k = 0; k < N; k++) begin
            re_v[k] = r;
            im_v[k] = i;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fcount = 0;
    endtask

    task automatic run_frame(input bit gaps, input int start_bin, input int rst_bin, input string name);
        int unsigned wr_base, done_base, se_base;
        bit ok;
        build_expected();
        wr_base   = wr_total;
        done_base = done_total;
        se_base   = seq_err;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({name, " busy_armed"}, 64'(busy), 64'd1);
        for (int k = 0; k < N; k++) begin
            if (k == rst_bin) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                check({name, " rst_busy"},  64'(busy),  64'd0);
                check({name, " rst_wr_en"}, 64'(wr_en), 64'd0);
                check({name, " rst_addr"},  64'(wr_addr), 64'd0);
                check({name, " rst_H"},     wr_data_H, 64'd0);
                check({name, " rst_P"},     wr_data_P, 64'd0);
                check({name, " rst_done"},  64'(done),  64'd0);
                @(posedge clk); #1 rst_n = 1'b1;
                fcount = 0;
                return;
            end
            start    = (k == start_bin);
            in_valid = 1'b1;
            fft_data = {im_v[k], re_v[k]};
            @(posedge clk); #1;
            acc_cyc[k] = cyc;
            if (gaps) begin
                start    = 1'b0;
                in_valid = 1'b0;
                fft_data = 64'hDEAD_BEEF_0BAD_F00D;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk); #1;
            if (done_total != done_base) ok = 1'b1;
        end
        check({name, " done_seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        check({name, " write_count"}, 64'(wr_total - wr_base), 64'(N));
        check({name, " addr_order"}, 64'(seq_err - se_base), 64'd0);
        check({name, " busy_after_done"}, 64'(busy), 64'd0);
        check({name, " done_timing"}, 64'(done_cyc), 64'(log_cyc[N-1] + 1));
        check({name, " last_write_timing"}, 64'(log_cyc[N-1]), 64'(log_cyc[N-2] + 1));
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s H[%0d]", name, k), log_H[k], exp_H[k]);
            check($sformatf("%s P[%0d]", name, k), log_P[k], exp_P[k]);
            if (k < N - 1)
                check($sformatf("%s wr_timing[%0d]", name, k), 64'(log_cyc[k]), 64'(acc_cyc[k+1] + 4));
        end
        for (int k = 0; k < N; k++) begin
            hist2_m[k] = hist1_m[k];
            hist1_m[k] = mag_m[k];
        end
        if (fcount < 2) fcount++;
    endtask

    logic [63:0] exp_m7, exp_big;

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",  64'(busy),  64'd0);
        check("reset wr_en", 64'(wr_en), 64'd0);
        check("reset addr",  64'(wr_addr), 64'd0);
        check("reset H",     wr_data_H, 64'd0);
        check("reset P",     wr_data_P, 64'd0);
        check("reset done",  64'(done),  64'd0);
        rst_n = 1'b1;
        fcount = 0;

        // constant 3+4j frame
        fill(32'sd3, 32'sd4);
        run_frame(1'b0, -1, -1, "t1");
`ifdef HPSS_MAG_L1_EN
        exp_m7 = 64'd7;
`else
        exp_m7 = 64'd25;
`endif
        check("t1 H0",    log_H[0],    exp_m7);
        check("t1 P0",    log_P[0],    exp_m7);
        check("t1 H1023", log_H[1023], exp_m7);
        check("t1 P1023", log_P[1023], exp_m7);

        // impulse at bin 5
        do_reset();
        fill(32'sd0, 32'sd0);
        re_v[5] = 32'sd10;
        run_frame(1'b0, -1, -1, "t2");
        check("t2 P4", log_P[4], 64'd0);
        check("t2 P5", log_P[5], 64'd0);
        check("t2 P6", log_P[6], 64'd0);
`ifdef HPSS_MAG_L1_EN
        check("t2 H5", log_H[5], 64'd10);
`else
        check("t2 H5", log_H[5], 64'd100);
`endif

        // time median over three frames at bin 7
        do_reset();
        fill(32'sd1, 32'sd0);
        re_v[7] = 32'sd10;
        run_frame(1'b0, -1, -1, "t3f0");
        re_v[7] = 32'sd0;
        run_frame(1'b0, -1, -1, "t3f1");
        check("t3 f1 H7", log_H[7], 64'd0);
        re_v[7] = 32'sd10;
        run_frame(1'b0, -1, -1, "t3f2");
`ifdef HPSS_MAG_L1_EN
        check("t3 f2 H7", log_H[7], 64'd10);
`else
        check("t3 f2 H7", log_H[7], 64'd100);
`endif

        // varied data, gap-free then with in_valid toggling
        for (int k = 0; k < N; k++) begin
            re_v[k] = 32'((k % 7) - 3);
            im_v[k] = 32'(((k * 5) % 11) - 5);
        end
        run_frame(1'b0, -1, -1, "t4a");
        for (int k = 0; k < N; k++) save_P[k] = log_P[k];
        run_frame(1'b1, -1, -1, "t4b");
        check("t4 gapP0",    log_P[0],    save_P[0]);
        check("t4 gapP511",  log_P[511],  save_P[511]);
        check("t4 gapP1023", log_P[1023], save_P[1023]);

        // start mid-frame is ignored; reset mid-frame clears everything
        run_frame(1'b0, 300, -1, "t5a");
        run_frame(1'b0, -1, 500, "t5b");
        fill(32'sd2, 32'sd0);
        run_frame(1'b0, -1, -1, "t5c");
`ifdef HPSS_MAG_L1_EN
        check("t5c H0", log_H[0], 64'd2);
`else
        check("t5c H0", log_H[0], 64'd4);
`endif

        // magnitude definition and extreme input
        do_reset();
        fill(-32'sd3, 32'sd4);
        run_frame(1'b0, -1, -1, "t6a");
        check("t6a H10", log_H[10], exp_m7);
        check("t6a P10", log_P[10], exp_m7);
        fill(32'sh8000_0000, 32'sh8000_0000);
        run_frame(1'b0, -1, -1, "t6b");
`ifdef HPSS_MAG_L1_EN
        exp_big = 64'h0000_0001_0000_0000;
`else
        exp_big = 64'h8000_0000_0000_0000;
`endif
        check("t6b H0",   log_H[0],   exp_big);
        check("t6b P512", log_P[512], exp_big);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
